// File: rtl/regfile_bank.sv
// Parametrised register bank: per-register RW / RO / write-pulse / W1C modes, byte-lane writes, 1- or 2-cycle read latency.
// Optional status interrupt output irq is built when REGFILE_IRQ_EN is defined.
module regfile_bank #(
  parameter int                   Naddr      = 4,
  parameter int                   Nbits      = 32,
  parameter int                   RD_LAT     = 1,
  parameter logic [2**Naddr-1:0]  RO_MASK    = '0,
  parameter logic [2**Naddr-1:0]  PULSE_MASK = '0,
  parameter logic [2**Naddr-1:0]  W1C_MASK   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [Naddr-1:0]              addr,
  input  logic [Nbits-1:0]              wr_data,
  input  logic [Nbits/8-1:0]            we,
  input  logic                          en,
  output logic [Nbits-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [(2**Naddr)*Nbits-1:0]   reg_val,
  output logic [(2**Naddr)*Nbits-1:0]   pul_val,
  input  logic [(2**Naddr)*Nbits-1:0]   read_val,
  input  logic [(2**Naddr)*Nbits-1:0]   set_val
`ifdef REGFILE_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int N = 2**Naddr;
  localparam int L = Nbits/8;

  // Effective modes after priority RO > W1C > PULSE > RW
  localparam logic [N-1:0] RO_M  = RO_MASK;
  localparam logic [N-1:0] W1C_M = W1C_MASK & ~RO_MASK;
  localparam logic [N-1:0] PUL_M = PULSE_MASK & ~RO_MASK & ~W1C_MASK;

  function automatic logic [Nbits-1:0] lane_mask(input logic [L-1:0] w);
    logic [Nbits-1:0] m;
    m = '0;
    for (int b = 0; b < L; b++) m[b*8 +: 8] = {8{w[b]}};
    return m;
  endfunction

  logic             wr;
  logic             rd;
  logic [Nbits-1:0] lane_m;

  assign wr     = en & (|we);
  assign rd     = en & ~(|we);
  assign lane_m = lane_mask(we);

  logic [Nbits-1:0] store_q [N];
  logic [Nbits-1:0] store_n [N];
  logic [Nbits-1:0] pul_q   [N];
  logic [Nbits-1:0] pul_n   [N];

  // RO and PULSE registers keep no state, so their store slots stay zero
  always_comb begin
    for (int i = 0; i < N; i++) begin
      store_n[i] = '0;
      pul_n[i]   = '0;
      if (W1C_M[i]) begin
        store_n[i] = (store_q[i] & ~((wr && addr == Naddr'(i)) ? (wr_data & lane_m) : '0))
                   | set_val[i*Nbits +: Nbits];
      end else if (PUL_M[i]) begin
        pul_n[i] = (wr && addr == Naddr'(i)) ? (wr_data & lane_m) : '0;
      end else if (!RO_M[i]) begin
        store_n[i] = (wr && addr == Naddr'(i)) ? ((store_q[i] & ~lane_m) | (wr_data & lane_m))
                                               : store_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        store_q[i] <= '0;
        pul_q[i]   <= '0;
      end
    end else begin
      store_q <= store_n;
      pul_q   <= pul_n;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign reg_val[gi*Nbits +: Nbits] = store_q[gi];
    assign pul_val[gi*Nbits +: Nbits] = pul_q[gi];
  end

  logic [Nbits-1:0] rd_src;
  assign rd_src = RO_M[addr] ? read_val[addr*Nbits +: Nbits] : store_q[addr];

  // Stage p0: first read register, captures the source on the en cycle
  logic             vld_p0;
  logic [Nbits-1:0] data_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd;
      if (rd) data_p0 <= rd_src;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    // Stage p1: optional second read register
    logic             vld_p1;
    logic [Nbits-1:0] data_p1;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = data_p1;
  end else begin : g_lat1
    assign rd_valid = vld_p0;
    assign rd_data  = data_p0;
  end

`ifdef REGFILE_IRQ_EN
  logic status_any;

  always_comb begin
    status_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (W1C_M[i]) status_any = status_any | (|store_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= status_any;
  end
`endif

endmodule
